// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// fc_layer_sequencer: address sweep and MAC strobe generator for the FC layer
// Revision: 1.0
// ============================================================================
module fc_layer_sequencer #(
  parameter int WIDTH   = 784,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic [ADDR_W-1:0] address,
  output logic              mac_clear,
  output logic              mac_valid,
  output logic              mac_last,
  output logic              busy,
  output logic              done
);

  if ((WIDTH > (2 ** ADDR_W)) || (WIDTH < 2)) begin : g_bad_width
    $error("fc_layer_sequencer: WIDTH must satisfy 2 <= WIDTH <= 2**ADDR_W");
  end
  if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_bad_lat
    $error("fc_layer_sequencer: MEM_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]  C_LAST_ADDR = ADDR_W'(WIDTH - 1);
  // Output stage of the delay line; only the stages behind it count as pending.
  localparam logic [MEM_LAT-1:0] C_OUT_STAGE = MEM_LAT'(1) << (MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_LAT-1:0]  vpipe_q, vpipe_d;
  logic [MEM_LAT-1:0]  lpipe_q, lpipe_d;
  logic                clear_q, busy_q, done_q;
  logic                issue, issue_last, pending;

  assign issue      = (state_q == S_RUN) && !hold;
  assign issue_last = issue && (addr_q == C_LAST_ADDR);
  assign pending    = |(vpipe_q & ~C_OUT_STAGE);
  assign vpipe_d    = (vpipe_q << 1) | MEM_LAT'(issue);
  assign lpipe_d    = (lpipe_q << 1) | MEM_LAT'(issue_last);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (issue) begin
          addr_d = issue_last ? '0 : addr_q + ADDR_W'(1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (!pending) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      vpipe_q <= '0;
      lpipe_q <= '0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vpipe_q <= vpipe_d;
      lpipe_q <= lpipe_d;
      clear_q <= (state_q == S_IDLE) && start;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign address   = addr_q;
  assign mac_clear = clear_q;
  assign mac_valid = vpipe_q[MEM_LAT-1];
  assign mac_last  = lpipe_q[MEM_LAT-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire
